mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Shares the single main-memory port between NUM_REQ L1 requesters (I-cache, D-cache). Round-robin arbitration;
//  one transaction in flight. Loads fetch a full line as LINE_WORDS read beats; stores write a single word.
//  Sits between the L1 controllers and the main-memory front end. Owns the request/response handshakes on both sides.
// PARAMETERS
//  NUM_REQ      2    number of requesters (>=2)
//  ADDR_W       32   word-address width
//  DATA_W       32   data word width
//  LINE_WORDS   8    words per line (power of 2); load addresses are aligned down to this
//  TIMEOUT_CYC  256  watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  CLK        in   1               clock, all state on posedge
//  RST_N      in   1               reset, asynchronous, active-low
//  REQ_VALID  in   NUM_REQ         per-requester request; held until its REQ_GNT bit pulses
//  REQ_STORE  in   NUM_REQ         1=store word, 0=load line
//  REQ_ADDR   in   NUM_REQ*ADDR_W  packed word addresses, requester i at [i*ADDR_W +: ADDR_W]
//  REQ_WDATA  in   NUM_REQ*DATA_W  packed store data
//  REQ_GNT    out  NUM_REQ         one-hot 1-cycle pulse: request captured
//  RSP_VALID  out  NUM_REQ         one-hot: RSP_DATA valid for that requester this cycle
//  RSP_DATA   out  DATA_W          read beat (0 on store completion)
//  RSP_LAST   out  1               final beat / store completion, qualified by RSP_VALID
//  RSP_ERR    out  1               transaction failed, qualified by RSP_VALID & RSP_LAST
//  MEM_VALID  out  1               request to memory, held until MEM_READY
//  MEM_STORE  out  1               1=store, 0=load
//  MEM_ADDR   out  ADDR_W          line-aligned for loads, exact for stores
//  MEM_WDATA  out  DATA_W          store data
//  MEM_READY  in   1               memory accepted request (MEM_VALID&MEM_READY = handshake)
//  MEM_RVALID in   1               read beat valid
//  MEM_RDATA  in   DATA_W          read beat data
//  MEM_WACK   in   1               store completed
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=0 (requester 0 highest priority first); beat counter=0.
//  FSM IDLE->GRANT: any REQ_VALID. GRANT (1 cyc): pick first valid at/after rr pointer, latch addr/data/op/id,
//   pulse REQ_GNT[id], pointer<=id+1 mod NUM_REQ. GRANT->ISSUE.
//  ISSUE: MEM_VALID=1 with latched fields; on MEM_READY -> WAIT (MEM_VALID drops next cycle).
//  WAIT load: each MEM_RVALID forwarded combinationally-registered: RSP_VALID[id], RSP_DATA=MEM_RDATA, 1-cycle latency;
//   beat counter increments; RSP_LAST on beat LINE_WORDS-1; then -> IDLE.
//  WAIT store: MEM_WACK -> RSP_VALID[id]=RSP_LAST=1, RSP_DATA=0 next cycle; -> IDLE.
//  MEM_WACK during load or MEM_RVALID during store: ignored. Beats after last: ignored (IDLE).
//  Requests arriving during a transaction wait; no starvation: winner drops to lowest priority.
//  Simultaneous: RSP_LAST cycle and new REQ_VALID -> GRANT occurs the cycle after return to IDLE (min 1 idle cycle).
//  Deasserting REQ_VALID before GNT withdraws the request; after GNT the transaction completes regardless.
//  Beat counter width $clog2(LINE_WORDS), wraps to 0 at RSP_LAST. Load addr = REQ_ADDR & ~(LINE_WORDS-1).
//  Reset mid-transaction: immediate abort, all outputs 0; memory side must also be reset.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined: counter starts on entering ISSUE; reaching TIMEOUT_CYC without completion
//   -> RSP_VALID[id]=RSP_LAST=RSP_ERR=1 one cycle, MEM_VALID=0, FSM->IDLE. Late beats/WACK then ignored.
//  Undefined: no watchdog, RSP_ERR tied 0, FSM waits indefinitely.
// STRUCTURE
//  Package mem_arb_pkg: state encoding (IDLE,GRANT,ISSUE,WAIT), LINE_OFF_W, default widths.
//  Sub-module rr_arbiter: NUM_REQ request vector + pointer -> one-hot grant + index (combinational).
// TESTING
//  1 Single load: R0 load addr 0x13 -> MEM_ADDR=0x10, GNT[0] pulse, 8 beats echoed to R0, RSP_LAST on 8th.
//  2 Contention: R0,R1 load same cycle after reset -> R0 served first, R1 next; repeat -> R1 then R0.
//  3 Store: R1 store addr 0x25 data 0xDEADBEEF -> MEM_ADDR=0x25, MEM_WDATA=0xDEADBEEF; WACK -> RSP_LAST to R1.
//  4 Back-pressure: MEM_READY low 5 cycles -> MEM_VALID and fields stable all 5 cycles, one handshake only.
//  5 Reset mid-load after beat 3 -> all outputs 0 next, fresh load afterwards correct with counter from 0.
//  6 TIMEOUT_EN, TIMEOUT_CYC=16, no WACK -> RSP_ERR+RSP_LAST at cycle 16 after ISSUE; late WACK ignored.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the main-memory request arbiter: FSM state
//   encoding, default parameter values and the line-offset width that
//   follows from the default line size.
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_LINE_WORDS  = 8;
    localparam int DEF_TIMEOUT_CYC = 256;
    localparam int LINE_OFF_W      = $clog2(DEF_LINE_WORDS);

endpackage

// File: rtl/mem_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// Bus interfaces for mem_req_arbiter.
//   mem_arb_req_if : L1 requesters <-> arbiter
//       master = requester side (drives valid/store/addr/wdata)
//       slave  = arbiter side   (drives gnt and the response channel)
//   mem_arb_mem_if : arbiter <-> main-memory front end
//       master = arbiter side   (drives valid/store/addr/wdata)
//       slave  = memory side    (drives ready, read beats and store ack)
// ----------------------------------------------------------------------------
interface mem_arb_req_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        valid;
    logic [NUM_REQ-1:0]        store;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_last;
    logic                      rsp_err;

    modport master (
        output valid, store, addr, wdata,
        input  gnt, rsp_valid, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  valid, store, addr, wdata,
        output gnt, rsp_valid, rsp_data, rsp_last, rsp_err
    );
endinterface

interface mem_arb_mem_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              valid;
    logic              store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              wack;

    modport master (
        output valid, store, addr, wdata,
        input  ready, rvalid, rdata, wack
    );

    modport slave (
        input  valid, store, addr, wdata,
        output ready, rvalid, rdata, wack
    );
endinterface

// File: rtl/mem_req_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first asserted request at or after
//   the pointer position (wrapping) wins.
// Ports
//   i_req  : request vector
//   i_ptr  : index of the highest-priority requester this round
//   o_gnt  : one-hot winner (all zero when no request)
//   o_idx  : binary index of the winner
//   o_any  : at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Scan from the farthest offset down to the pointer so the closest
    // request overwrites earlier candidates.
    always_comb begin
        int j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[IDX_W'(j)]) begin
                o_gnt              = '0;
                o_gnt[IDX_W'(j)]   = 1'b1;
                o_idx              = IDX_W'(j);
                o_any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// mem_req_arbiter
//   Shares one main-memory port between NUM_REQ L1 requesters with
//   round-robin arbitration and a single transaction in flight. Loads fetch a
//   whole line (LINE_WORDS read beats, address aligned down); stores write one
//   word and complete on the memory ack.
// Ports
//   i_clk    : clock, all state on rising edge
//   i_rst_n  : asynchronous active-low reset
//   req_bus  : requester side (request, one-cycle grant pulse, responses)
//   mem_bus  : memory side (request held until ready, read beats, store ack)
// Configuration
//   MEM_ARB_TIMEOUT_EN : when defined, a watchdog of TIMEOUT_CYC cycles
//   starting on entry to ISSUE ends a stuck transaction with an error
//   response. Otherwise the FSM waits indefinitely and rsp_err is 0.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no transaction; move to GRANT when any request is present
// ST_GRANT | pick winner, latch its fields; gnt and mem valid rise on exit
// ST_ISSUE | mem request held until mem ready
// ST_WAIT  | forward read beats / wait for store ack, then back to IDLE
// ----------------------------------------------------------------------------
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
    input  logic          i_clk,
    input  logic          i_rst_n,
    mem_arb_req_if.slave  req_bus,
    mem_arb_mem_if.master mem_bus
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("mem_req_arbiter: NUM_REQ must be at least 2");
    end
    if ((LINE_WORDS < 2) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0)) begin : g_bad_line
        $error("mem_req_arbiter: LINE_WORDS must be a power of 2, at least 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_tmo
        $error("mem_req_arbiter: TIMEOUT_CYC must be at least 2");
    end

    arb_state_t          r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]  r_sel;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_last;
    logic                r_store;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_mem_valid;
    logic [BEAT_W-1:0]   r_beat;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_store;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic                w_last_beat;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req (req_bus.valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_sel_addr  = req_bus.addr[int'(w_idx)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_bus.wdata[int'(w_idx)*DATA_W +: DATA_W];
    assign w_sel_store = req_bus.store[w_idx];
    // Winner drops to lowest priority for the next round.
    assign w_ptr_nxt   = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_last_beat = (r_beat == BEAT_W'(LINE_WORDS - 1));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] r_tmo;
    logic             r_rsp_err;
    logic             w_done;

    // A normal completion in the terminal cycle wins over the watchdog.
    assign w_done = (r_state == ST_WAIT) &&
                    (r_store ? mem_bus.wack : (mem_bus.rvalid && w_last_beat));
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_store     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_valid <= 1'b0;
            r_beat      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_tmo       <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (|req_bus.valid) r_state <= ST_GRANT;
                end
                ST_GRANT: begin
                    // A request withdrawn before the grant leaves nothing to pick.
                    if (w_any) begin
                        r_sel       <= w_gnt;
                        r_gnt       <= w_gnt;
                        r_ptr       <= w_ptr_nxt;
                        r_store     <= w_sel_store;
                        r_addr      <= w_sel_store ? w_sel_addr : (w_sel_addr & LINE_MASK);
                        r_wdata     <= w_sel_wdata;
                        r_mem_valid <= 1'b1;
                        r_beat      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_tmo       <= TMO_W'(TIMEOUT_CYC - 1);
`endif
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_bus.ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!r_store && mem_bus.rvalid) begin
                        r_rsp_valid <= r_sel;
                        r_rsp_data  <= mem_bus.rdata;
                        r_rsp_last  <= w_last_beat;
                        r_beat      <= r_beat + 1'b1;
                        if (w_last_beat) r_state <= ST_IDLE;
                    end else if (r_store && mem_bus.wack) begin
                        r_rsp_valid <= r_sel;
                        r_rsp_last  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef MEM_ARB_TIMEOUT_EN
            if (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && !w_done) begin
                if (r_tmo == '0) begin
                    r_rsp_valid <= r_sel;
                    r_rsp_data  <= '0;
                    r_rsp_last  <= 1'b1;
                    r_rsp_err   <= 1'b1;
                    r_mem_valid <= 1'b0;
                    r_beat      <= '0;
                    r_state     <= ST_IDLE;
                end else begin
                    r_tmo <= r_tmo - 1'b1;
                end
            end
`endif
        end
    end

    assign req_bus.gnt       = r_gnt;
    assign req_bus.rsp_valid = r_rsp_valid;
    assign req_bus.rsp_data  = r_rsp_data;
    assign req_bus.rsp_last  = r_rsp_last;
`ifdef MEM_ARB_TIMEOUT_EN
    assign req_bus.rsp_err   = r_rsp_err;
`else
    assign req_bus.rsp_err   = 1'b0;
`endif

    assign mem_bus.valid = r_mem_valid;
    assign mem_bus.store = r_store;
    assign mem_bus.addr  = r_addr;
    assign mem_bus.wdata = r_wdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_req_arbiter
//   Directed bench for mem_req_arbiter: single load, contention/rotation,
//   store, memory back-pressure, request withdrawal, reset mid-load and the
//   watchdog (or its absence, depending on MEM_ARB_TIMEOUT_EN).
// ----------------------------------------------------------------------------
module tb_mem_req_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   hs_cnt;

    mem_arb_req_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) req_bus ();
    mem_arb_mem_if #(.ADDR_W(32), .DATA_W(32))              mem_bus ();

    mem_req_arbiter #(
        .NUM_REQ     (2),
        .ADDR_W      (32),
        .DATA_W      (32),
        .LINE_WORDS  (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .req_bus (req_bus),
        .mem_bus (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_bus.valid && mem_bus.ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt_rsp"}, {req_bus.gnt, req_bus.rsp_valid}, 0);
        check({tag, "_rdata"}, req_bus.rsp_data, 0);
        check({tag, "_flags"}, {req_bus.rsp_last, req_bus.rsp_err, mem_bus.valid, mem_bus.store}, 0);
        check({tag, "_maddr"}, mem_bus.addr, 0);
        check({tag, "_mwdata"}, mem_bus.wdata, 0);
    endtask

    task automatic post_req(input int id, input logic st, input logic [31:0] a, input logic [31:0] wd);
        req_bus.store[id]           = st;
        req_bus.addr[id*32 +: 32]   = a;
        req_bus.wdata[id*32 +: 32]  = wd;
        req_bus.valid[id]           = 1'b1;
    endtask

    // Requests must already be presented while the arbiter is idle.
    task automatic run_txn(input int id, input logic st, input logic [31:0] exp_addr,
                           input logic [31:0] wd, input int bp, input logic [31:0] dbase);
        int hs0;
        hs0 = hs_cnt;
        cyc();
        check("grant_cyc_gnt", req_bus.gnt, 0);
        check("grant_cyc_mv", mem_bus.valid, 0);
        check("grant_cyc_rsp", req_bus.rsp_valid, 0);
        cyc();
        check("gnt", req_bus.gnt, 64'(1 << id));
        check("mem_valid", mem_bus.valid, 1);
        check("mem_addr", mem_bus.addr, exp_addr);
        check("mem_store", mem_bus.store, st);
        if (st) check("mem_wdata", mem_bus.wdata, wd);
        req_bus.valid[id] = 1'b0;
        for (int i = 0; i < bp; i++) begin
            cyc();
            check("bp_valid", mem_bus.valid, 1);
            check("bp_fields", {mem_bus.store, mem_bus.addr}, {st, exp_addr});
            check("bp_gnt", req_bus.gnt, 0);
        end
        mem_bus.ready = 1'b1;
        cyc();
        mem_bus.ready = 1'b0;
        check("mv_drop", mem_bus.valid, 0);
        if (!st) begin
            for (int k = 0; k < 8; k++) begin
                mem_bus.rvalid = 1'b1;
                mem_bus.rdata  = dbase + 32'(k);
                mem_bus.wack   = (k == 2);
                cyc();
                check("beat_valid", req_bus.rsp_valid, 64'(1 << id));
                check("beat_data", req_bus.rsp_data, dbase + 32'(k));
                check("beat_last", req_bus.rsp_last, (k == 7) ? 1 : 0);
            end
            mem_bus.rvalid = 1'b0;
            mem_bus.wack   = 1'b0;
        end else begin
            mem_bus.rvalid = 1'b1;
            mem_bus.rdata  = 32'hBAD0_0000;
            cyc();
            mem_bus.rvalid = 1'b0;
            check("st_rvalid_ignored", req_bus.rsp_valid, 0);
            mem_bus.wack = 1'b1;
            cyc();
            mem_bus.wack = 1'b0;
            check("st_rsp_valid", req_bus.rsp_valid, 64'(1 << id));
            check("st_rsp_last", req_bus.rsp_last, 1);
            check("st_rsp_data", req_bus.rsp_data, 0);
            check("st_rsp_err", req_bus.rsp_err, 0);
        end
        check("handshakes", 64'(hs_cnt - hs0), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_bus.valid  = '0;
        mem_bus.ready  = 1'b0;
        mem_bus.rvalid = 1'b0;
        mem_bus.wack   = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int early;
        n_checks = 0;
        n_errors = 0;
        hs_cnt   = 0;
        rst_n    = 1'b0;
        req_bus.valid  = '0;
        req_bus.store  = '0;
        req_bus.addr   = '0;
        req_bus.wdata  = '0;
        mem_bus.ready  = 1'b0;
        mem_bus.rvalid = 1'b0;
        mem_bus.rdata  = '0;
        mem_bus.wack   = 1'b0;

        repeat (3) cyc();
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc();
        check_all_zero("idle");

        // Single load, address aligned down to the line; beats after last ignored.
        post_req(0, 1'b0, 32'h13, 32'h0);
        run_txn(0, 1'b0, 32'h10, 32'h0, 0, 32'h1000_0000);
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = 32'h5555_5555;
        cyc();
        mem_bus.rvalid = 1'b0;
        check("late_beat_ignored", req_bus.rsp_valid, 0);

        // Contention after reset: R0 then R1; after R0 alone, R1 wins first.
        do_reset();
        post_req(0, 1'b0, 32'h100, 32'h0);
        post_req(1, 1'b0, 32'h208, 32'h0);
        run_txn(0, 1'b0, 32'h100, 32'h0, 0, 32'h2000_0000);
        run_txn(1, 1'b0, 32'h208, 32'h0, 0, 32'h2100_0000);
        post_req(0, 1'b0, 32'h31F, 32'h0);
        run_txn(0, 1'b0, 32'h318, 32'h0, 0, 32'h2200_0000);
        post_req(0, 1'b0, 32'h400, 32'h0);
        post_req(1, 1'b0, 32'h507, 32'h0);
        run_txn(1, 1'b0, 32'h500, 32'h0, 0, 32'h2300_0000);
        run_txn(0, 1'b0, 32'h400, 32'h0, 0, 32'h2400_0000);

        // Store: exact address and data.
        post_req(1, 1'b1, 32'h25, 32'hDEAD_BEEF);
        run_txn(1, 1'b1, 32'h25, 32'hDEAD_BEEF, 0, 32'h0);

        // Back-pressure: ready low for 5 cycles.
        post_req(0, 1'b0, 32'h1FF, 32'h0);
        run_txn(0, 1'b0, 32'h1F8, 32'h0, 5, 32'h3000_0000);

        // Withdrawn before grant: no grant, back to idle.
        post_req(1, 1'b0, 32'h600, 32'h0);
        cyc();
        req_bus.valid[1] = 1'b0;
        cyc();
        check("withdraw_gnt", req_bus.gnt, 0);
        check("withdraw_mv", mem_bus.valid, 0);
        cyc();
        check("withdraw_idle", {req_bus.gnt, mem_bus.valid}, 0);

        // Reset after beat 3 of a load, then a fresh load counts from beat 0.
        post_req(0, 1'b0, 32'h44, 32'h0);
        cyc();
        cyc();
        check("rst_load_gnt", req_bus.gnt, 1);
        req_bus.valid[0] = 1'b0;
        mem_bus.ready = 1'b1;
        cyc();
        mem_bus.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_bus.rvalid = 1'b1;
            mem_bus.rdata  = 32'hA000 + 32'(k);
            cyc();
            check("rst_load_beat", req_bus.rsp_data, 32'hA000 + 32'(k));
        end
        mem_bus.rdata = 32'hA003;
        #1;
        rst_n = 1'b0;
        #1;
        mem_bus.rvalid = 1'b0;
        check_all_zero("abort");
        cyc();
        cyc();
        rst_n = 1'b1;
        post_req(1, 1'b0, 32'h77, 32'h0);
        run_txn(1, 1'b0, 32'h70, 32'h0, 0, 32'hB000_0000);

        // Store with no ack: watchdog error, or indefinite wait without it.
        post_req(1, 1'b1, 32'h30, 32'h1234_5678);
        cyc();
        cyc();
        check("tmo_gnt", req_bus.gnt, 2);
        req_bus.valid[1] = 1'b0;
        mem_bus.ready = 1'b1;
        cyc();
        mem_bus.ready = 1'b0;
        check("tmo_mv_drop", mem_bus.valid, 0);
        early = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int j = 2; j <= 15; j++) begin
            cyc();
            if (req_bus.rsp_valid != 0) early++;
        end
        check("tmo_early", early, 0);
        cyc();
        check("tmo_rsp_valid", req_bus.rsp_valid, 2);
        check("tmo_rsp_last", req_bus.rsp_last, 1);
        check("tmo_rsp_err", req_bus.rsp_err, 1);
        check("tmo_mv", mem_bus.valid, 0);
        mem_bus.wack = 1'b1;
        cyc();
        mem_bus.wack = 1'b0;
        check("tmo_late_wack", req_bus.rsp_valid, 0);
        cyc();
        check("tmo_after", {req_bus.rsp_valid, req_bus.rsp_err}, 0);
`else
        for (int j = 0; j < 40; j++) begin
            cyc();
            if ((req_bus.rsp_valid != 0) || req_bus.rsp_err) early++;
        end
        check("no_tmo_quiet", early, 0);
        mem_bus.wack = 1'b1;
        cyc();
        mem_bus.wack = 1'b0;
        check("no_tmo_rsp_valid", req_bus.rsp_valid, 2);
        check("no_tmo_rsp_last", req_bus.rsp_last, 1);
        check("no_tmo_rsp_err", req_bus.rsp_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
